// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among N_REQ requesters. A round-robin
//   arbiter grants one requester at a time. The granted WORD_BYTES-byte word
//   is captured and streamed to the tx LSB byte first over the tx's
//   start/done handshake. When the last byte has left the line, a one-cycle
//   ack pulse goes back to the requester.
//
// Ports
//   i_clk, i_reset   clock; synchronous active-high reset
//   i_req[N_REQ]     level requests, held until the matching ack
//   i_word           packed words, requester k owns slice k
//   o_ack[N_REQ]     one-cycle pulse: requester's word fully transmitted
//   o_grant[N_REQ]   one-hot owner of the tx, 0 when idle
//   o_busy           high whenever the FSM is not idle
//   o_tx_start       to tx i_tx_start
//   o_tx_data        to tx i_data, stable while o_tx_start is high
//   i_tx_done        from tx o_tx_done (high = tx idle)
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int WORD_BYTES = 4,
  parameter int DBIT       = 8
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [N_REQ-1:0]                  i_req,
  input  logic [N_REQ*WORD_BYTES*DBIT-1:0]  i_word,
  output logic [N_REQ-1:0]                  o_ack,
  output logic [N_REQ-1:0]                  o_grant,
  output logic                              o_busy,
  output logic                              o_tx_start,
  output logic [DBIT-1:0]                   o_tx_data,
  input  logic                              i_tx_done
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int WORD_W = WORD_BYTES * DBIT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_ACK
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                tx_start_q, tx_start_d;
  logic [DBIT-1:0]     tx_data_q, tx_data_d;

  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [WORD_W-1:0]   word_sel;
  logic [WORD_W-1:0]   shift_nxt;

  // (base + off) mod N_REQ; off < N_REQ so a single subtract is enough.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IDX_W-1:0];
  endfunction

  // Round-robin pick: first set request at or above rr_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && i_req[wrap_add(rr_q, i)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(rr_q, i);
      end
    end
  end

  assign word_sel  = i_word[idx_q*WORD_W +: WORD_W];
  assign shift_nxt = shift_q >> DBIT;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;

    unique case (state_q)
      S_IDLE: begin
        // A low done here means the tx is still finishing someone else's
        // frame, so arbitration waits until the line is free.
        if (i_tx_done && pick_found) begin
          grant_d = N_REQ'(1) << pick_idx;
          idx_d   = pick_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Word is sampled here only; later changes on i_word are ignored.
        // Start is raised on the way into START so the first byte is
        // offered two cycles after arbitration.
        shift_d    = word_sel;
        byte_cnt_d = '0;
        tx_start_d = 1'b1;
        tx_data_d  = word_sel[DBIT-1:0];
        state_d    = S_START;
      end
      S_START: begin
        // The tx only samples start on a baud tick; done falling is the
        // acceptance. Start must be gone before done rises again.
        if (!i_tx_done) begin
          tx_start_d = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_tx_done) begin
          if (byte_cnt_q == CNT_W'(WORD_BYTES - 1)) begin
            ack_d   = grant_q;
            state_d = S_ACK;
          end else begin
            shift_d    = shift_nxt;
            byte_cnt_d = byte_cnt_q + 1'b1;
            tx_start_d = 1'b1;
            tx_data_d  = shift_nxt[DBIT-1:0];
            state_d    = S_START;
          end
        end
      end
      S_ACK: begin
        // Served requester drops to lowest priority.
        rr_d    = wrap_add(idx_q, 1);
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_grant    = grant_q;
  assign o_busy     = busy_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: behavioural tx model, requester queues,
// round-robin reference model and byte/ack scoreboards.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int WB    = 4;
  localparam int DB    = 8;
  localparam int WW    = WB * DB;
  localparam int TICK  = 4;
  localparam int FRAME = 10 * TICK;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic [N-1:0]      i_req = '0;
  logic [N*WW-1:0]   i_word = '0;
  logic [N-1:0]      o_ack, o_grant;
  logic              o_busy, o_tx_start;
  logic [DB-1:0]     o_tx_data;
  logic              i_tx_done;

  always #5 i_clk = ~i_clk;

  uart_tx_arbiter #(.N_REQ(N), .WORD_BYTES(WB), .DBIT(DB)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_word(i_word),
    .o_ack(o_ack), .o_grant(o_grant), .o_busy(o_busy),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_done(i_tx_done)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endfunction

  function automatic void fail(string name);
    chk_cnt++;
    $display("FAIL %s: got unexpected event, want none", name);
  endfunction

  // ---------------- requesters ----------------
  logic [WW-1:0] wq [N][$];
  logic [N-1:0]  hide = '0;

  // Runs after the stimulus at each posedge; pops on ack, drives req/word.
  always begin
    @(posedge i_clk);
    #2;
    for (int k = 0; k < N; k++)
      if (o_ack[k] && wq[k].size() > 0) void'(wq[k].pop_front());
    for (int k = 0; k < N; k++) begin
      if (wq[k].size() > 0 && !hide[k]) begin
        i_req[k]            = 1'b1;
        i_word[k*WW +: WW]  = wq[k][0];
      end else begin
        i_req[k]            = 1'b0;
        i_word[k*WW +: WW]  = $urandom;
      end
    end
  end

  // ---------------- tx model ----------------
  int            tcnt = 0;
  int            bcnt = 0;
  bit            tbusy = 1'b0;
  bit            foreign = 1'b0;
  logic [DB-1:0] line_q[$];
  logic [DB-1:0] line_log[$];

  assign i_tx_done = !tbusy && !foreign;

  always @(posedge i_clk) begin
    tcnt <= (tcnt == TICK - 1) ? 0 : tcnt + 1;
    if (tbusy) begin
      if (bcnt == 1) tbusy <= 1'b0;
      bcnt <= bcnt - 1;
    end else if (!foreign && tcnt == 0 && o_tx_start) begin
      tbusy <= 1'b1;
      bcnt  <= FRAME;
      line_q.push_back(o_tx_data);
      line_log.push_back(o_tx_data);
    end
  end

  // ---------------- reference model + monitor ----------------
  logic [N-1:0]  req_prev = '0, grant_prev = '0;
  int            rr_m = 0;
  logic [DB-1:0] exp_bytes[$];
  int            exp_ack[$];
  int            grant_log[$];
  int            ack_total = 0;
  bit            rst_prev = 1'b0, start_chk = 1'b0, ack_chk = 1'b0;

  always @(negedge i_clk) begin
    if (i_reset) begin
      exp_bytes.delete(); exp_ack.delete(); line_q.delete();
      rr_m = 0; grant_prev = '0; start_chk = 0; ack_chk = 0; rst_prev = 1;
      req_prev = i_req;
    end else begin
      if (rst_prev) begin
        check("reset_outs", {o_ack, o_grant, o_busy, o_tx_start, o_tx_data}, 64'd0);
        line_q.delete();
        rst_prev = 0;
      end
      if (start_chk) begin
        check("start_2cyc", o_tx_start, 1);
        start_chk = 0;
      end
      if (grant_prev == '0 && o_grant != '0) begin
        int e;
        e = -1;
        for (int i = 0; i < N; i++)
          if (e < 0 && req_prev[(rr_m + i) % N]) e = (rr_m + i) % N;
        if (e < 0 || wq[e].size() == 0) fail("grant_unexp");
        else begin
          logic [WW-1:0] w;
          check("grant", o_grant, 64'(1) << e);
          w = wq[e][0];
          for (int b = 0; b < WB; b++) exp_bytes.push_back(w[b*DB +: DB]);
          exp_ack.push_back(e);
          grant_log.push_back(e);
          start_chk = 1;
        end
      end
      while (line_q.size() > 0) begin
        logic [DB-1:0] b;
        b = line_q.pop_front();
        if (exp_bytes.size() == 0) fail("line_extra");
        else check("line_byte", b, exp_bytes.pop_front());
      end
      if (ack_chk) begin
        check("ack_1cyc", o_ack, 0);
        ack_chk = 0;
      end else if (o_ack != '0) begin
        ack_total++;
        if (exp_ack.size() == 0) fail("ack_unexp");
        else begin
          int e;
          e = exp_ack.pop_front();
          check("ack_idx", o_ack, 64'(1) << e);
          check("ack_after_line", {exp_bytes.size() == 0, i_tx_done}, 2'b11);
          rr_m = (e + 1) % N;
        end
        ack_chk = 1;
      end
      grant_prev = o_grant;
      req_prev   = i_req;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick(2);
    i_reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge i_clk);
      done = !o_busy && exp_ack.size() == 0 && exp_bytes.size() == 0;
      for (int k = 0; k < N; k++) if (wq[k].size() > 0) done = 0;
    end
    if (!done) fail("timeout_idle");
    tick(1);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c;
    c = 0;
    while (line_log.size() < n && c < budget) begin tick(1); c++; end
    if (line_log.size() < n) fail("timeout_bytes");
  endtask

  function automatic logic [31:0] pack_grants();
    logic [31:0] v;
    v = '0;
    foreach (grant_log[i]) v = (v << 4) | 32'(grant_log[i]);
    return v;
  endfunction

  function automatic logic [31:0] pack_line();
    logic [31:0] v;
    v = '0;
    foreach (line_log[i]) v = (v << 8) | 32'(line_log[i]);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    int acks0;
    tick(3);
    i_reset = 1'b0;

    // 1: idle with no requests
    bad = 0;
    repeat (100) begin
      @(negedge i_clk);
      if ({o_ack, o_grant, o_busy, o_tx_start, o_tx_data} != '0) bad = 1;
    end
    check("idle_100", bad, 0);
    tick(1);

    // 2: single request
    line_log.delete(); grant_log.delete();
    wq[0].push_back(32'hDDCCBBAA);
    wait_idle(2000);
    check("t2_bytes", pack_line(), 32'hAABBCCDD);
    check("t2_grants", pack_grants(), 32'h0);

    // 3: fairness with all four requesting
    do_reset();
    grant_log.delete();
    wq[0].push_back($urandom); wq[0].push_back($urandom);
    for (int k = 1; k < N; k++) wq[k].push_back($urandom);
    wait_idle(8000);
    check("t3_order", pack_grants(), 32'h01230);

    // 4: wrap from requester 3
    grant_log.delete();
    wq[3].push_back($urandom);
    wait_idle(2000);
    wq[0].push_back($urandom); wq[3].push_back($urandom);
    wait_idle(4000);
    check("t4_order", pack_grants(), 32'h303);

    // 5: req drop and word change after byte 1
    line_log.delete();
    acks0 = ack_total;
    wq[2].push_back(32'h44332211);
    wait_bytes(2, 2000);
    hide[2] = 1'b1;
    wait_idle(2000);
    hide = '0;
    check("t5_bytes", pack_line(), 32'h11223344);
    check("t5_ack", ack_total - acks0, 1);

    // tx busy with a foreign frame: no arbitration
    foreign = 1'b1;
    wq[1].push_back($urandom);
    bad = 0;
    repeat (30) begin
      @(negedge i_clk);
      if (o_grant != '0 || o_busy) bad = 1;
    end
    check("foreign_hold", bad, 0);
    tick(1);
    foreign = 1'b0;
    wait_idle(2000);

    // 6: reset mid-word; rr restarts at requester 0
    grant_log.delete(); line_log.delete();
    acks0 = ack_total;
    wq[1].push_back($urandom); wq[3].push_back($urandom);
    wait_bytes(2, 2000);
    do_reset();
    wait_idle(6000);
    check("t6_order", pack_grants(), 32'h313);
    check("t6_acks", ack_total - acks0, 2);

    // random traffic
    for (int i = 0; i < 30; i++) begin
      wq[$urandom_range(0, N-1)].push_back($urandom);
      tick($urandom_range(0, 150));
    end
    wait_idle(30000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
